// File: rtl/misr_pkg.sv
// Shared types and constants for the MISR signature compactor.
// State encoding, window-counter width and a default feedback-polynomial table.
package misr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned CNT_W = 16;

    // Primitive (maximal-length) tap masks for the supported standard widths.
    localparam logic [31:0] POLY_W4  = 32'h0000_0003;
    localparam logic [31:0] POLY_W8  = 32'h0000_001D;
    localparam logic [31:0] POLY_W16 = 32'h0000_100B;
    localparam logic [31:0] POLY_W32 = 32'h04C1_1DB7;

    function automatic logic [31:0] default_poly(input int unsigned width);
        logic [31:0] poly;
        case (width)
            4:       poly = POLY_W4;
            8:       poly = POLY_W8;
            16:      poly = POLY_W16;
            32:      poly = POLY_W32;
            default: poly = 32'h0;
        endcase
        return poly;
    endfunction

endpackage

// File: rtl/misr_core.sv
// Galois multiple-input signature register: next-state function plus state register.
// Load has priority over enable; the register resets to SEED.
module misr_core #(
    parameter int unsigned      WIDTH = 16,
    parameter int unsigned      N_IN  = 3,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(32'h0000_100B),
    parameter logic [WIDTH-1:0] SEED  = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [N_IN-1:0]  d_i,
    output logic [WIDTH-1:0] state_o,
    output logic [WIDTH-1:0] next_o
);

    logic [WIDTH-1:0] misr_q;
    logic [WIDTH-1:0] misr_d;
    logic [WIDTH-1:0] misr_next;
    logic [WIDTH-1:0] d_ext;
    logic [WIDTH-1:0] taps;
    logic             fb;

    always_comb begin
        fb               = misr_q[WIDTH-1];
        d_ext            = '0;
        d_ext[N_IN-1:0]  = d_i;
        // Stage 0 always takes the feedback bit, whatever POLY[0] says.
        taps             = POLY | WIDTH'(1);
        misr_next        = {misr_q[WIDTH-2:0], 1'b0} ^ (taps & {WIDTH{fb}}) ^ d_ext;
    end

    always_comb begin
        misr_d = misr_q;
        if (load_i) begin
            misr_d = SEED;
        end else if (en_i) begin
            misr_d = misr_next;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            misr_q <= SEED;
        end else begin
            misr_q <= misr_d;
        end
    end

    assign state_o = misr_q;
    assign next_o  = misr_next;

endmodule

// File: rtl/misr_sig_compactor.sv
// Windowed MISR signature compactor: IDLE/RUN/DONE control, window counter, signature capture.
// Optional golden comparison compiled in with MISR_GOLDEN_CMP_EN.
module misr_sig_compactor
    import misr_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned N_IN   = 3,
    parameter logic [31:0] POLY   = 32'h0000_100B,
    parameter logic [31:0] SEED   = 32'h0000_0000,
    parameter int unsigned WINDOW = 256,
    parameter logic [31:0] GOLDEN = 32'h0000_0000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             en,
    input  logic [N_IN-1:0]  d,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sig,
    output logic             pass
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WINDOW - 1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;
    logic             misr_load;
    logic             misr_step;
    logic             capture;
    logic [WIDTH-1:0] misr_state;
    logic [WIDTH-1:0] misr_next;

    misr_core #(
        .WIDTH (WIDTH),
        .N_IN  (N_IN),
        .POLY  (POLY[WIDTH-1:0]),
        .SEED  (SEED[WIDTH-1:0])
    ) u_misr_core (
        .clk_i   (CLK),
        .rst_i   (RST),
        .load_i  (misr_load),
        .en_i    (misr_step),
        .d_i     (d),
        .state_o (misr_state),
        .next_o  (misr_next)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sig_d     = sig_q;
        misr_load = 1'b0;
        misr_step = 1'b0;
        capture   = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    misr_load = 1'b1;
                    cnt_d     = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                // A restart wins over the data qualifier on the same cycle.
                if (start) begin
                    misr_load = 1'b1;
                    cnt_d     = '0;
                end else if (en) begin
                    misr_step = 1'b1;
                    if (cnt_q == LastCnt) begin
                        capture = 1'b1;
                        sig_d   = misr_next;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sig_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sig_q   <= sig_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sig  = sig_q;

`ifdef MISR_GOLDEN_CMP_EN
    logic pass_q;
    logic pass_d;

    always_comb begin
        pass_d = pass_q;
        if (misr_load) begin
            pass_d = 1'b0;
        end else if (capture) begin
            pass_d = (misr_next == GOLDEN[WIDTH-1:0]);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pass_q <= 1'b0;
        end else begin
            pass_q <= pass_d;
        end
    end

    assign pass = pass_q;
`else
    assign pass = 1'b0;
`endif

    // The live register value is only observed through the captured signature.
    logic unused_misr_state;
    assign unused_misr_state = ^misr_state;

endmodule

// File: tb/tb_misr_sig_compactor.sv
// Scoreboard bench for misr_sig_compactor: expectations queued at start, popped when done rises.
// Honours MISR_GOLDEN_CMP_EN for the expected pass value.
module tb_misr_sig_compactor;

`ifdef MISR_GOLDEN_CMP_EN
    localparam bit CmpEn = 1'b1;
`else
    localparam bit CmpEn = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] sig;
        logic       pass;
    } exp_t;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    // Instance A: WIDTH 4, POLY 3, SEED 0, WINDOW 8, 3 channels.
    logic       start_a, en_a, busy_a, done_a, pass_a;
    logic [2:0] d_a;
    logic [3:0] sig_a;
    // Instances B/G: SEED 1, WINDOW 15, 1 channel, GOLDEN 1 and 2, shared inputs.
    logic       start_b, en_b, busy_b, done_b, pass_b, busy_g, done_g, pass_g;
    logic [0:0] d_b;
    logic [3:0] sig_b, sig_g;
    // Instance C: WINDOW 1, 3 channels.
    logic       start_c, en_c, busy_c, done_c, pass_c;
    logic [2:0] d_c;
    logic [3:0] sig_c;

    misr_sig_compactor #(.WIDTH(4), .N_IN(3), .POLY(32'h3), .SEED(32'h0), .WINDOW(8),
                         .GOLDEN(32'h0)) u_dut_a (
        .CLK(CLK), .RST(RST), .start(start_a), .en(en_a), .d(d_a),
        .busy(busy_a), .done(done_a), .sig(sig_a), .pass(pass_a));

    misr_sig_compactor #(.WIDTH(4), .N_IN(1), .POLY(32'h3), .SEED(32'h1), .WINDOW(15),
                         .GOLDEN(32'h1)) u_dut_b (
        .CLK(CLK), .RST(RST), .start(start_b), .en(en_b), .d(d_b),
        .busy(busy_b), .done(done_b), .sig(sig_b), .pass(pass_b));

    misr_sig_compactor #(.WIDTH(4), .N_IN(1), .POLY(32'h3), .SEED(32'h1), .WINDOW(15),
                         .GOLDEN(32'h2)) u_dut_g (
        .CLK(CLK), .RST(RST), .start(start_b), .en(en_b), .d(d_b),
        .busy(busy_g), .done(done_g), .sig(sig_g), .pass(pass_g));

    misr_sig_compactor #(.WIDTH(4), .N_IN(3), .POLY(32'h3), .SEED(32'h0), .WINDOW(1),
                         .GOLDEN(32'h0)) u_dut_c (
        .CLK(CLK), .RST(RST), .start(start_c), .en(en_c), .d(d_c),
        .busy(busy_c), .done(done_c), .sig(sig_c), .pass(pass_c));

    exp_t q_a[$], q_b[$], q_g[$], q_c[$];
    exp_t e_a, e_b, e_g, e_c;
    logic done_a_d = 1'b0, done_b_d = 1'b0, done_g_d = 1'b0, done_c_d = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic exp_t mk(input logic [3:0] s, input logic [3:0] golden);
        exp_t e;
        e.sig  = s;
        e.pass = CmpEn && (s == golden);
        return e;
    endfunction

    always @(negedge CLK) begin
        if (done_a && !done_a_d) begin
            if (q_a.size() == 0) chk("a_unexpected_done", {31'b0, done_a}, 32'h0);
            else begin
                e_a = q_a.pop_front();
                chk("a_sig", {28'b0, sig_a}, {28'b0, e_a.sig});
                chk("a_pass", {31'b0, pass_a}, {31'b0, e_a.pass});
            end
        end
        done_a_d <= done_a;
    end

    always @(negedge CLK) begin
        if (done_b && !done_b_d) begin
            if (q_b.size() == 0) chk("b_unexpected_done", {31'b0, done_b}, 32'h0);
            else begin
                e_b = q_b.pop_front();
                chk("b_sig", {28'b0, sig_b}, {28'b0, e_b.sig});
                chk("b_pass", {31'b0, pass_b}, {31'b0, e_b.pass});
            end
        end
        done_b_d <= done_b;
    end

    always @(negedge CLK) begin
        if (done_g && !done_g_d) begin
            if (q_g.size() == 0) chk("g_unexpected_done", {31'b0, done_g}, 32'h0);
            else begin
                e_g = q_g.pop_front();
                chk("g_sig", {28'b0, sig_g}, {28'b0, e_g.sig});
                chk("g_pass", {31'b0, pass_g}, {31'b0, e_g.pass});
            end
        end
        done_g_d <= done_g;
    end

    always @(negedge CLK) begin
        if (done_c && !done_c_d) begin
            if (q_c.size() == 0) chk("c_unexpected_done", {31'b0, done_c}, 32'h0);
            else begin
                e_c = q_c.pop_front();
                chk("c_sig", {28'b0, sig_c}, {28'b0, e_c.sig});
                chk("c_pass", {31'b0, pass_c}, {31'b0, e_c.pass});
            end
        end
        done_c_d <= done_c;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_a_pulse();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic step_a(input logic e, input logic [2:0] dv);
        en_a = e;
        d_a  = dv;
        tick();
    endtask

    initial begin
        RST = 1'b1;
        start_a = 1'b0; en_a = 1'b0; d_a = '0;
        start_b = 1'b0; en_b = 1'b0; d_b = '0;
        start_c = 1'b0; en_c = 1'b0; d_c = '0;
        tick();
        tick();
        chk("rst_busy_a", {31'b0, busy_a}, 32'h0);
        chk("rst_done_a", {31'b0, done_a}, 32'h0);
        chk("rst_sig_a", {28'b0, sig_a}, 32'h0);
        chk("rst_pass_a", {31'b0, pass_a}, 32'h0);
        chk("rst_sig_b", {28'b0, sig_b}, 32'h0);
        chk("rst_done_c", {31'b0, done_c}, 32'h0);
        RST = 1'b0;
        tick();
        tick();
        chk("idle_after_rst", {30'b0, busy_a, done_a}, 32'h0);

        // All-zero data from a zero seed stays zero; done one cycle after the 8th enable.
        q_a.push_back(mk(4'h0, 4'h0));
        start_a_pulse();
        for (int i = 0; i < 7; i++) step_a(1'b1, 3'b000);
        chk("a_done_early", {31'b0, done_a}, 32'h0);
        chk("a_busy_run", {31'b0, busy_a}, 32'h1);
        step_a(1'b1, 3'b000);
        chk("a_done_latency", {31'b0, done_a}, 32'h1);
        chk("a_busy_done", {31'b0, busy_a}, 32'h0);
        step_a(1'b0, 3'b000);

        // d=001 for 8 cycles: 1,3,7,F,C,A,6,D.
        q_a.push_back(mk(4'hD, 4'h0));
        start_a_pulse();
        for (int i = 0; i < 8; i++) step_a(1'b1, 3'b001);
        step_a(1'b1, 3'b111);
        step_a(1'b1, 3'b111);
        chk("a_done_hold_sig", {28'b0, sig_a}, 32'hD);
        chk("a_done_hold", {31'b0, done_a}, 32'h1);

        // Alternate enables with junk data on idle cycles: same signature, 16 RUN cycles.
        q_a.push_back(mk(4'hD, 4'h0));
        start_a_pulse();
        for (int i = 0; i < 16; i++) begin
            step_a(i % 2 == 1, (i % 2 == 1) ? 3'b001 : 3'b111);
            if (i == 5) chk("a_sig_retained", {28'b0, sig_a}, 32'hD);
            if (i == 14) chk("a_alt_done_early", {31'b0, done_a}, 32'h0);
        end
        chk("a_alt_done", {31'b0, done_a}, 32'h1);

        // Async reset at count 5, then a mid-run restart yields the full-window signature.
        start_a_pulse();
        for (int i = 0; i < 5; i++) step_a(1'b1, 3'b001);
        chk("a_busy_pre_rst", {31'b0, busy_a}, 32'h1);
        #2 RST = 1'b1;
        #1;
        chk("a_rst_busy_async", {31'b0, busy_a}, 32'h0);
        chk("a_rst_sig_async", {28'b0, sig_a}, 32'h0);
        tick();
        RST = 1'b0;
        en_a = 1'b1;
        tick();
        tick();
        chk("a_idle_no_start", {30'b0, busy_a, done_a}, 32'h0);
        q_a.push_back(mk(4'hD, 4'h0));
        start_a_pulse();
        for (int i = 0; i < 3; i++) step_a(1'b1, 3'b111);
        start_a = 1'b1;
        step_a(1'b1, 3'b111);
        start_a = 1'b0;
        chk("a_restart_busy", {31'b0, busy_a}, 32'h1);
        for (int i = 0; i < 8; i++) step_a(1'b1, 3'b001);
        chk("a_restart_done", {31'b0, done_a}, 32'h1);
        en_a = 1'b0;

        // Maximal-length period: 15 zero-input steps return the seed.
        q_b.push_back(mk(4'h1, 4'h1));
        q_g.push_back(mk(4'h1, 4'h2));
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        en_b = 1'b1;
        d_b = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("b_done_early", {31'b0, done_b}, 32'h0);
        tick();
        chk("b_done_latency", {31'b0, done_b}, 32'h1);
        en_b = 1'b0;
        tick();

        // Single-cycle window: the channels land directly in the low stages.
        q_c.push_back(mk(4'h1, 4'h0));
        q_c.push_back(mk(4'h5, 4'h0));
        q_c.push_back(mk(4'h6, 4'h0));
        for (int k = 0; k < 3; k++) begin
            start_c = 1'b1;
            en_c = 1'b1;
            d_c = 3'b111;
            tick();
            start_c = 1'b0;
            d_c = (k == 0) ? 3'b001 : (k == 1) ? 3'b101 : 3'b110;
            tick();
            chk("c_done_latency", {31'b0, done_c}, 32'h1);
            en_c = 1'b0;
            tick();
        end

        tick();
        tick();
        chk("a_queue_drained", q_a.size(), 32'h0);
        chk("b_queue_drained", q_b.size(), 32'h0);
        chk("g_queue_drained", q_g.size(), 32'h0);
        chk("c_queue_drained", q_c.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
